omsp_atom_irq_scheduler: RTL and testbench



---
 rtl/omsp_atom_irq_scheduler_pkg.sv | 14 +
 rtl/omsp_irq_prio_select.sv | 40 ++++
 rtl/omsp_atom_irq_scheduler.sv | 136 +++++++++++++
 tb/tb_omsp_atom_irq_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/omsp_atom_irq_scheduler_pkg.sv
// Shared types and defaults for the atomicity-aware IRQ scheduler.
// Optional round-robin arbitration is selected with ATOM_IRQ_ROUND_ROBIN_EN.
package omsp_atom_irq_scheduler_pkg;

    localparam int DEFAULT_NUM_IRQ   = 14;
    localparam int DEFAULT_MAX_DEFER = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DEFER = 2'b01,
        ST_GRANT = 2'b10
    } sched_state_t;

endpackage

// File: rtl/omsp_irq_prio_select.sv
// Combinational winner select over the pending vector.
// ATOM_IRQ_ROUND_ROBIN_EN: search upward from rr_ptr with wrap; otherwise highest index wins.
module omsp_irq_prio_select #(
    parameter int NUM_IRQ = 14,
    parameter int IRQ_W   = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] pending,
`ifdef ATOM_IRQ_ROUND_ROBIN_EN
    input  logic [IRQ_W-1:0]   rr_ptr,
`endif
    output logic [IRQ_W-1:0]   winner,
    output logic               any
);

`ifdef ATOM_IRQ_ROUND_ROBIN_EN
    function automatic logic [IRQ_W-1:0] wrap_idx(input logic [IRQ_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_IRQ) s = s - NUM_IRQ;
        return IRQ_W'(s);
    endfunction
`endif

    always_comb begin
        winner = '0;
`ifdef ATOM_IRQ_ROUND_ROBIN_EN
        // Walk from the farthest offset back to rr_ptr so the nearest set bit wins.
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (pending[wrap_idx(rr_ptr, k)]) winner = wrap_idx(rr_ptr, k);
        end
`else
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (pending[i]) winner = IRQ_W'(i);
        end
`endif
    end

    assign any = |pending;

endmodule

// File: rtl/omsp_atom_irq_scheduler.sv
// Latches IRQ requests, holds them back while effective GIE is low, presents one grant at a time
// and measures deferral. Macro ATOM_IRQ_ROUND_ROBIN_EN switches to round-robin arbitration.
module omsp_atom_irq_scheduler
    import omsp_atom_irq_scheduler_pkg::*;
#(
    parameter int NUM_IRQ   = DEFAULT_NUM_IRQ,
    parameter int MAX_DEFER = DEFAULT_MAX_DEFER,
    parameter int IRQ_W     = $clog2(NUM_IRQ),
    parameter int DEFER_W   = $clog2(MAX_DEFER + 1)
) (
    input  logic               mclk,
    input  logic               puc_rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               gie,
    input  logic               atom_violation,
    input  logic               irq_ack,
    output logic               irq_valid,
    output logic [IRQ_W-1:0]   irq_num,
    output logic [NUM_IRQ-1:0] irq_pending,
    output logic [DEFER_W-1:0] defer_cnt,
    output logic               defer_overrun,
    output logic [1:0]         fsm_state
);

    sched_state_t       state;
    logic               ack_eff;
    logic [NUM_IRQ-1:0] ack_mask;
    logic [NUM_IRQ-1:0] pending_rem;
    logic [NUM_IRQ-1:0] pending_next;
    logic [DEFER_W-1:0] cnt_inc;
    logic [IRQ_W-1:0]   sel_winner;
    logic               sel_any;

    assign ack_eff      = irq_ack && (state == ST_GRANT);
    assign ack_mask     = ack_eff ? (NUM_IRQ'(1) << irq_num) : '0;
    // Arbitration looks at the registered vector minus the bit being acked, so the
    // next grant follows an ack without an idle cycle.
    assign pending_rem  = irq_pending & ~ack_mask;
    assign pending_next = (irq_pending | irq_in) & ~ack_mask;
    assign cnt_inc      = (defer_cnt == DEFER_W'(MAX_DEFER)) ? defer_cnt : defer_cnt + 1'b1;
    assign fsm_state    = state;

`ifdef ATOM_IRQ_ROUND_ROBIN_EN
    logic [IRQ_W-1:0] rr_ptr;
    logic [IRQ_W-1:0] ptr_inc;
    logic [IRQ_W-1:0] sel_ptr;

    assign ptr_inc = (irq_num == IRQ_W'(NUM_IRQ - 1)) ? '0 : irq_num + 1'b1;
    assign sel_ptr = ack_eff ? ptr_inc : rr_ptr;

    always_ff @(posedge mclk) begin
        if (puc_rst)      rr_ptr <= '0;
        else if (ack_eff) rr_ptr <= ptr_inc;
    end
`endif

    omsp_irq_prio_select #(
        .NUM_IRQ (NUM_IRQ),
        .IRQ_W   (IRQ_W)
    ) u_select (
        .pending (pending_rem),
`ifdef ATOM_IRQ_ROUND_ROBIN_EN
        .rr_ptr  (sel_ptr),
`endif
        .winner  (sel_winner),
        .any     (sel_any)
    );

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state         <= ST_IDLE;
            irq_pending   <= '0;
            irq_valid     <= 1'b0;
            irq_num       <= '0;
            defer_cnt     <= '0;
            defer_overrun <= 1'b0;
        end else begin
            irq_pending   <= pending_next;
            defer_overrun <= 1'b0;
            if (atom_violation) begin
                state     <= ST_IDLE;
                irq_valid <= 1'b0;
                defer_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (sel_any) begin
                            if (gie) begin
                                state     <= ST_GRANT;
                                irq_valid <= 1'b1;
                                irq_num   <= sel_winner;
                            end else begin
                                state <= ST_DEFER;
                            end
                        end
                    end
                    ST_DEFER: begin
                        defer_cnt     <= cnt_inc;
                        defer_overrun <= (defer_cnt == DEFER_W'(MAX_DEFER - 1));
                        if (gie) begin
                            if (sel_any) begin
                                state     <= ST_GRANT;
                                irq_valid <= 1'b1;
                                irq_num   <= sel_winner;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    ST_GRANT: begin
                        if (irq_ack) begin
                            defer_cnt <= '0;
                            if (!sel_any) begin
                                state     <= ST_IDLE;
                                irq_valid <= 1'b0;
                            end else if (gie) begin
                                irq_num <= sel_winner;
                            end else begin
                                state     <= ST_DEFER;
                                irq_valid <= 1'b0;
                            end
                        end else if (!gie) begin
                            state     <= ST_DEFER;
                            irq_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        irq_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_omsp_atom_irq_scheduler.sv
// Self-checking bench for omsp_atom_irq_scheduler: vector table, corner-case sequences
// and randomized traffic against a rule-level reference model.
module tb_omsp_atom_irq_scheduler;

    localparam int NUM  = 14;
    localparam int MAXD = 8;
    localparam int IW   = $clog2(NUM);
    localparam int DW   = $clog2(MAXD + 1);

    logic            mclk;
    logic            puc_rst;
    logic [NUM-1:0]  d_irq;
    logic            d_gie;
    logic            d_viol;
    logic            d_ack;
    logic            irq_valid;
    logic [IW-1:0]   irq_num;
    logic [NUM-1:0]  irq_pending;
    logic [DW-1:0]   defer_cnt;
    logic            defer_overrun;
    logic [1:0]      fsm_state;

    int n_tests = 0;
    int n_fail  = 0;

    omsp_atom_irq_scheduler #(
        .NUM_IRQ   (NUM),
        .MAX_DEFER (MAXD)
    ) dut (
        .mclk           (mclk),
        .puc_rst        (puc_rst),
        .irq_in         (d_irq),
        .gie            (d_gie),
        .atom_violation (d_viol),
        .irq_ack        (d_ack),
        .irq_valid      (irq_valid),
        .irq_num        (irq_num),
        .irq_pending    (irq_pending),
        .defer_cnt      (defer_cnt),
        .defer_overrun  (defer_overrun),
        .fsm_state      (fsm_state)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    logic [NUM-1:0] m_pend;
    bit             m_valid, m_defer, m_over;
    int             m_num, m_cnt, m_ptr;

    function automatic int pick(input logic [NUM-1:0] v);
`ifdef ATOM_IRQ_ROUND_ROBIN_EN
        for (int k = 0; k < NUM; k++) if (v[(m_ptr + k) % NUM]) return (m_ptr + k) % NUM;
`else
        for (int i = NUM - 1; i >= 0; i--) if (v[i]) return i;
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_valid = 0; m_defer = 0; m_over = 0;
        m_num = 0; m_cnt = 0; m_ptr = 0;
    endtask

    task automatic model_step();
        logic [NUM-1:0] np, rem;
        bit ack;
        ack = d_ack && m_valid;
        np  = m_pend | d_irq;
        rem = m_pend;
        if (ack) begin
            np[m_num]  = 1'b0;
            rem[m_num] = 1'b0;
            m_ptr = (m_num == NUM - 1) ? 0 : m_num + 1;
        end
        m_over = 0;
        if (d_viol) begin
            m_valid = 0; m_defer = 0; m_cnt = 0;
        end else if (m_valid) begin
            if (ack) begin
                m_cnt = 0;
                if (rem == 0) m_valid = 0;
                else if (d_gie) m_num = pick(rem);
                else begin m_valid = 0; m_defer = 1; end
            end else if (!d_gie) begin
                m_valid = 0; m_defer = 1;
            end
        end else if (m_defer) begin
            if (m_cnt == MAXD - 1) m_over = 1;
            if (m_cnt < MAXD) m_cnt++;
            if (d_gie) begin
                m_defer = 0;
                if (rem != 0) begin m_valid = 1; m_num = pick(rem); end
            end
        end else if (m_pend != 0) begin
            if (d_gie) begin m_valid = 1; m_num = pick(m_pend); end
            else m_defer = 1;
        end
        m_pend = np;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [NUM-1:0] irq, input bit gie, input bit viol, input bit ack);
        d_irq = irq; d_gie = gie; d_viol = viol; d_ack = ack;
    endtask

    task automatic step();
        @(posedge mclk);
        if (puc_rst) model_reset();
        else model_step();
        #1;
    endtask

    task automatic do_reset();
        drive('0, 0, 0, 0);
        puc_rst = 1'b1;
        step(); step();
        puc_rst = 1'b0;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_valid"}, int'(irq_valid), int'(m_valid));
        if (m_valid) chk({tag, "_num"}, int'(irq_num), m_num);
        chk({tag, "_pending"}, int'(irq_pending), int'(m_pend));
        chk({tag, "_defer_cnt"}, int'(defer_cnt), m_cnt);
        chk({tag, "_overrun"}, int'(defer_overrun), int'(m_over));
        chk({tag, "_state"}, int'(fsm_state), m_valid ? 2 : (m_defer ? 1 : 0));
    endtask

    typedef struct {
        logic [NUM-1:0] irq;
        bit             gie;
        bit             ack;
        bit             e_valid;
        int             e_num;
        int             e_pend;
        int             e_state;
    } vec_t;

    vec_t vecs[17];
    int   ovr_seen;
    int   last_grant;
    int   grants;
    bit   gie_lvl;

    initial begin
        puc_rst = 1'b1;
        drive('0, 0, 0, 0);
        do_reset();
        chk("reset_valid", int'(irq_valid), 0);
        chk("reset_num", int'(irq_num), 0);
        chk("reset_pending", int'(irq_pending), 0);
        chk("reset_defer_cnt", int'(defer_cnt), 0);
        chk("reset_overrun", int'(defer_overrun), 0);
        chk("reset_state", int'(fsm_state), 0);

`ifndef ATOM_IRQ_ROUND_ROBIN_EN
        // irq, gie, ack -> valid, num, pending, state
        vecs[0]  = '{14'h0008, 1, 0, 0, 0, 'h0008, 0};
        vecs[1]  = '{14'h0000, 1, 0, 1, 3, 'h0008, 2};
        vecs[2]  = '{14'h0000, 1, 0, 1, 3, 'h0008, 2};
        vecs[3]  = '{14'h0000, 1, 1, 0, 0, 'h0000, 0};
        vecs[4]  = '{14'h0204, 1, 0, 0, 0, 'h0204, 0};
        vecs[5]  = '{14'h0000, 1, 0, 1, 9, 'h0204, 2};
        vecs[6]  = '{14'h0000, 1, 1, 1, 2, 'h0004, 2};
        vecs[7]  = '{14'h0000, 1, 1, 0, 0, 'h0000, 0};
        vecs[8]  = '{14'h0080, 1, 0, 0, 0, 'h0080, 0};
        vecs[9]  = '{14'h0080, 1, 0, 1, 7, 'h0080, 2};
        vecs[10] = '{14'h0080, 1, 1, 0, 0, 'h0000, 0};
        vecs[11] = '{14'h0080, 1, 0, 0, 0, 'h0080, 0};
        vecs[12] = '{14'h0000, 1, 0, 1, 7, 'h0080, 2};
        vecs[13] = '{14'h0000, 1, 1, 0, 0, 'h0000, 0};
        vecs[14] = '{14'h0080, 1, 1, 0, 0, 'h0080, 0};
        vecs[15] = '{14'h0000, 1, 0, 1, 7, 'h0080, 2};
        vecs[16] = '{14'h0000, 1, 1, 0, 0, 'h0000, 0};
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].irq, vecs[i].gie, 0, vecs[i].ack);
            step();
            chk($sformatf("vec%0d_valid", i), int'(irq_valid), int'(vecs[i].e_valid));
            if (vecs[i].e_valid) chk($sformatf("vec%0d_num", i), int'(irq_num), vecs[i].e_num);
            chk($sformatf("vec%0d_pending", i), int'(irq_pending), vecs[i].e_pend);
            chk($sformatf("vec%0d_state", i), int'(fsm_state), vecs[i].e_state);
        end
`else
        // Two levels held high: successive grants must alternate.
        last_grant = -1;
        grants = 0;
        for (int i = 0; i < 20; i++) begin
            drive(14'h0042, 1, 0, irq_valid);
            step();
            if (irq_valid && (d_ack || last_grant == -1 || int'(irq_num) != last_grant)) begin
                if (last_grant != -1) chk("rr_alternate", int'(irq_num == IW'(last_grant)), 0);
                last_grant = int'(irq_num);
                grants++;
            end
        end
        chk("rr_grant_count_ok", int'(grants >= 4), 1);
        do_reset();
`endif

        // Deferral with saturation and a single overrun pulse.
        drive(14'h0020, 0, 0, 0); step();
        chk("defer_pend", int'(irq_pending), 'h20);
        ovr_seen = 0;
        for (int i = 0; i < 10; i++) begin
            drive('0, 0, 0, 0); step();
            if (defer_overrun) begin
                ovr_seen++;
                chk("overrun_at_max", int'(defer_cnt), MAXD);
            end
        end
        chk("defer_saturated", int'(defer_cnt), MAXD);
        chk("overrun_once", ovr_seen, 1);
        chk("defer_state", int'(fsm_state), 1);
        chk("defer_no_valid", int'(irq_valid), 0);
        drive('0, 1, 0, 0); step();
        chk("defer_grant_valid", int'(irq_valid), 1);
        chk("defer_grant_num", int'(irq_num), 5);
        drive('0, 1, 0, 1); step();
        chk("defer_ack_cnt", int'(defer_cnt), 0);
        chk("defer_ack_pend", int'(irq_pending), 0);
        chk("defer_ack_state", int'(fsm_state), 0);

        // Withdraw when gie drops before ack.
        drive(14'h0010, 1, 0, 0); step();
        drive('0, 1, 0, 0); step();
        chk("wd_grant_num", int'(irq_num), 4);
        chk("wd_grant_valid", int'(irq_valid), 1);
        drive('0, 0, 0, 0); step();
        chk("wd_valid_low", int'(irq_valid), 0);
        chk("wd_pend_kept", int'(irq_pending), 'h10);
        chk("wd_state", int'(fsm_state), 1);
        chk("wd_cnt_held", int'(defer_cnt), 0);
        drive('0, 1, 0, 0); step();
        chk("wd_regrant_valid", int'(irq_valid), 1);
        chk("wd_regrant_num", int'(irq_num), 4);
        chk("wd_regrant_cnt", int'(defer_cnt), 1);
        drive('0, 1, 0, 1); step();
        chk("wd_ack_pend", int'(irq_pending), 0);

        // Violation during grant, then violation coinciding with ack.
        drive(14'h0800, 1, 0, 0); step();
        drive('0, 1, 0, 0); step();
        drive('0, 0, 0, 0); step();
        drive('0, 1, 0, 0); step();
        chk("viol_pre_cnt", int'(defer_cnt), 1);
        chk("viol_pre_num", int'(irq_num), 11);
        drive('0, 1, 1, 0); step();
        chk("viol_valid", int'(irq_valid), 0);
        chk("viol_cnt", int'(defer_cnt), 0);
        chk("viol_pend", int'(irq_pending), 'h800);
        chk("viol_state", int'(fsm_state), 0);
        drive('0, 1, 0, 0); step();
        chk("viol_regrant_valid", int'(irq_valid), 1);
        chk("viol_regrant_num", int'(irq_num), 11);
        drive('0, 1, 1, 1); step();
        chk("viol_ack_pend", int'(irq_pending), 0);
        chk("viol_ack_valid", int'(irq_valid), 0);
        drive('0, 1, 0, 0); step();
        chk("viol_ack_idle", int'(fsm_state), 0);

        // Randomized traffic against the model.
        do_reset();
        gie_lvl = 1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 11) == 0) gie_lvl = ~gie_lvl;
            drive(($urandom_range(0, 3) == 0) ? NUM'($urandom & $urandom) : '0,
                  gie_lvl,
                  $urandom_range(0, 40) == 0,
                  $urandom_range(0, 1) == 1);
            step();
            chk_model($sformatf("rnd%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
